// File: rtl/frame_painter_pkg.sv
// Shared constants, widths and FSM state type for the frame painter.
// Default raster is 320x240 with 3-bit RGB colour.
package frame_painter_pkg;

    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int COLOUR_W  = 3;
    localparam int PIPE_W    = 1 + X_W + Y_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/frame_painter_coord_delay.sv
// Parameterised shift register that delays {valid, x, y} by DEPTH cycles,
// matching the pixel-source latency so coordinates line up with colour.
module coord_delay
    import frame_painter_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = PIPE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign data_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/frame_painter.sv
// Raster scanner: requests every pixel of a frame from a latency-SRC_LAT
// source and forwards the aligned coordinate/colour/plot to a VGA adapter.
module frame_painter
    import frame_painter_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int SRC_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                continuous,
    output logic [X_W-1:0]      req_x,
    output logic [Y_W-1:0]      req_y,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                frame_done
);

    localparam logic [X_W-1:0] X_LAST     = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_RES - 1);
    localparam logic [2:0]     LAST_DRAIN = 3'(SRC_LAT - 1);

    state_e          state_q;
    logic [X_W-1:0]  req_x_q, req_x_d;
    logic [Y_W-1:0]  req_y_q, req_y_d;
    logic [2:0]      drain_cnt_q;
    logic            busy_q;
    logic            frame_done_q;
    logic            last_pix;
    logic            scan_vld;
    logic [PIPE_W-1:0] dly_out;

    always_comb begin
        last_pix = (req_x_q == X_LAST) && (req_y_q == Y_LAST);
        req_x_d  = req_x_q + X_W'(1);
        req_y_d  = req_y_q;
        if (req_x_q == X_LAST) begin
            req_x_d = '0;
            req_y_d = req_y_q + Y_W'(1);
        end
    end

    // frame_done is raised in the final DRAIN cycle, which is also the cycle
    // the last pixel is plotted; continuous mode re-enters SCAN right after.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_x_q      <= '0;
            req_y_q      <= '0;
            drain_cnt_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_done_q <= 1'b0;
                    req_x_q      <= '0;
                    req_y_q      <= '0;
                    if (start || continuous) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (last_pix) begin
                        state_q      <= DRAIN;
                        drain_cnt_q  <= '0;
                        frame_done_q <= (LAST_DRAIN == 3'd0);
                    end else begin
                        req_x_q <= req_x_d;
                        req_y_q <= req_y_d;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == LAST_DRAIN) begin
                        frame_done_q <= 1'b0;
                        req_x_q      <= '0;
                        req_y_q      <= '0;
                        if (continuous) begin
                            state_q <= SCAN;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        drain_cnt_q  <= drain_cnt_q + 3'd1;
                        frame_done_q <= ((drain_cnt_q + 3'd1) == LAST_DRAIN);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign scan_vld = (state_q == SCAN);

    coord_delay #(
        .DEPTH (SRC_LAT),
        .W     (PIPE_W)
    ) u_coord_delay (
        .clk    (clk),
        .reset  (reset),
        .data_i ({scan_vld, req_x_q, req_y_q}),
        .data_o (dly_out)
    );

    assign {plot, x, y} = dly_out;
    assign colour       = colour_in;
    assign req_x        = req_x_q;
    assign req_y        = req_y_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_frame_painter.sv
// Bench for frame_painter: a 320x4 raster with 1-cycle source and a 4x2
// raster with 3-cycle source, checked against an expected-pixel scoreboard.
module tb_frame_painter;

    localparam int H_A = 320, V_A = 4, LAT_A = 1, N_A = H_A * V_A;
    localparam int H_B = 4,   V_B = 2, LAT_B = 3, N_B = H_B * V_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, start_a = 1'b0, cont_a = 1'b0;
    logic [8:0] rx_a, x_a;
    logic [7:0] ry_a, y_a;
    logic [2:0] cin_a, col_a;
    logic       plot_a, busy_a, done_a;

    logic       rst_b = 1'b1, start_b = 1'b0, cont_b = 1'b0;
    logic [8:0] rx_b, x_b;
    logic [7:0] ry_b, y_b;
    logic [2:0] cin_b, col_b;
    logic       plot_b, busy_b, done_b;

    frame_painter #(.H_RES(H_A), .V_RES(V_A), .SRC_LAT(LAT_A)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .continuous(cont_a),
        .req_x(rx_a), .req_y(ry_a), .colour_in(cin_a),
        .x(x_a), .y(y_a), .colour(col_a), .plot(plot_a),
        .busy(busy_a), .frame_done(done_a)
    );

    frame_painter #(.H_RES(H_B), .V_RES(V_B), .SRC_LAT(LAT_B)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .continuous(cont_b),
        .req_x(rx_b), .req_y(ry_b), .colour_in(cin_b),
        .x(x_b), .y(y_b), .colour(col_b), .plot(plot_b),
        .busy(busy_b), .frame_done(done_b)
    );

    // Pixel sources: colour = {x[0], y[0], 1} after the source latency.
    logic [2:0] src_a;
    logic [2:0] src_b [3];
    always @(posedge clk) begin
        src_a    <= {rx_a[0], ry_a[0], 1'b1};
        src_b[0] <= {rx_b[0], ry_b[0], 1'b1};
        src_b[1] <= src_b[0];
        src_b[2] <= src_b[1];
    end
    assign cin_a = src_a;
    assign cin_b = src_b[2];

    typedef struct {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic rst, st, ct;
        logic bsy, plt, dn;
        logic [8:0] ex;
        logic [7:0] ey;
        logic [8:0] erx;
        string nm;
    } row_t;

    pix_t qa[$], qb[$];
    int   fp_a[$], dn_a[$], fp_b[$], dn_b[$];
    int   pcnt_a = 0, pcnt_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    bit   mon_a = 1'b0, mon_b = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000000;
    endfunction

    task automatic push_frame(input bit b, input int h, input int v);
        pix_t p;
        for (int yy = 0; yy < v; yy++) begin
            for (int xx = 0; xx < h; xx++) begin
                p.x = 9'(xx);
                p.y = 8'(yy);
                p.c = {p.x[0], p.y[0], 1'b1};
                if (b) qb.push_back(p);
                else   qa.push_back(p);
            end
        end
    endtask

    task automatic clear_logs();
        fp_a.delete(); dn_a.delete(); fp_b.delete(); dn_b.delete();
        pcnt_a = 0; pcnt_b = 0;
    endtask

    // One clock: advance to the falling edge and score whatever the DUTs show.
    task automatic step();
        pix_t e;
        @(negedge clk);
        cyc++;
        if (mon_a) begin
            if (plot_a) begin
                if (!prev_a) fp_a.push_back(cyc);
                pcnt_a++;
                if (qa.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL pix_a_extra: got plot at x=%0d y=%0d, required no plot", x_a, y_a);
                end else begin
                    e = qa.pop_front();
                    chk("pix_a", 32'({x_a, y_a, col_a}), 32'({e.x, e.y, e.c}));
                end
            end
            if (done_a) begin
                dn_a.push_back(cyc);
                chk("done_a_with_last_plot", 32'(plot_a), 1);
                chk("plots_per_frame_a", pcnt_a, N_A);
                chk("plot_contiguous_a", cyc - q_at(fp_a, fp_a.size() - 1) + 1, N_A);
                pcnt_a = 0;
            end
        end
        if (mon_b) begin
            if (plot_b) begin
                if (!prev_b) fp_b.push_back(cyc);
                pcnt_b++;
                if (qb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL pix_b_extra: got plot at x=%0d y=%0d, required no plot", x_b, y_b);
                end else begin
                    e = qb.pop_front();
                    chk("pix_b", 32'({x_b, y_b, col_b}), 32'({e.x, e.y, e.c}));
                end
            end
            if (done_b) begin
                dn_b.push_back(cyc);
                chk("done_b_with_last_plot", 32'(plot_b), 1);
                chk("plots_per_frame_b", pcnt_b, N_B);
                chk("plot_contiguous_b", cyc - q_at(fp_b, fp_b.size() - 1) + 1, N_B);
                pcnt_b = 0;
            end
        end
        prev_a = plot_a;
        prev_b = plot_b;
    endtask

    task automatic wait_done(input bit b, input int cnt, input int budget);
        int t;
        t = 0;
        while (((b ? dn_b.size() : dn_a.size()) < cnt) && t < budget) begin
            step();
            t++;
        end
        chk(b ? "done_b_reached" : "done_a_reached", b ? dn_b.size() : dn_a.size(), cnt);
    endtask

    row_t tbl[11];
    int   c0;
    int   t;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 9'd0, "rst_over_start"};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 9'd0, "rst_over_cont"};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 9'd0, "idle_hold"};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0, 9'd0, "start_busy"};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 8'd0, 9'd1, "first_plot"};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd1, 8'd0, 9'd2, "second_plot"};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 9'd2, 8'd0, 9'd3, "start_busy_ignored"};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 9'd0, "rst_abort"};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 9'd0, "idle_after_abort"};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0, 9'd0, "cont_starts"};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 9'd0, "rst_abort_cont"};

        repeat (3) step();
        chk("reset_a_ctl", 32'({busy_a, plot_a, done_a, x_a, y_a}), 0);
        chk("reset_a_req", 32'({rx_a, ry_a}), 0);
        chk("reset_b_ctl", 32'({busy_b, plot_b, done_b, x_b, y_b}), 0);
        chk("reset_b_req", 32'({rx_b, ry_b}), 0);

        for (int i = 0; i < 11; i++) begin
            rst_a = tbl[i].rst; start_a = tbl[i].st; cont_a = tbl[i].ct;
            step();
            chk(tbl[i].nm, 32'({busy_a, plot_a, done_a, x_a, y_a, rx_a}),
                32'({tbl[i].bsy, tbl[i].plt, tbl[i].dn, tbl[i].ex, tbl[i].ey, tbl[i].erx}));
        end
        rst_a = 1'b0; start_a = 1'b0; cont_a = 1'b0;
        rst_b = 1'b0;
        step();
        mon_a = 1'b1; mon_b = 1'b1;
        clear_logs();

        // Single frame with a stray start partway through.
        c0 = cyc; start_a = 1'b1; push_frame(1'b0, H_A, V_A);
        step(); start_a = 1'b0;
        while (cyc < c0 + 500) step();
        start_a = 1'b1; step(); start_a = 1'b0;
        wait_done(1'b0, 1, N_A + 50);
        repeat (5) step();
        chk("a_first_plot_lat", q_at(fp_a, 0) - c0, 1 + LAT_A);
        chk("a_frame_period", q_at(dn_a, 0) - c0, N_A + LAT_A);
        chk("a_one_done", dn_a.size(), 1);
        chk("a_queue_empty", qa.size(), 0);
        chk("a_idle_after", 32'({busy_a, plot_a}), 0);

        // Three continuous frames, continuous dropped during the third.
        clear_logs();
        c0 = cyc; cont_a = 1'b1;
        push_frame(1'b0, H_A, V_A); push_frame(1'b0, H_A, V_A); push_frame(1'b0, H_A, V_A);
        wait_done(1'b0, 2, 2 * (N_A + LAT_A) + 50);
        repeat (10) step();
        cont_a = 1'b0;
        wait_done(1'b0, 3, N_A + 50);
        repeat (N_A + 20) step();
        chk("cont_done_count", dn_a.size(), 3);
        chk("cont_first_period", q_at(dn_a, 0) - c0, N_A + LAT_A);
        chk("cont_spacing_1", q_at(dn_a, 1) - q_at(dn_a, 0), N_A + LAT_A);
        chk("cont_spacing_2", q_at(dn_a, 2) - q_at(dn_a, 1), N_A + LAT_A);
        chk("cont_plot_gap_1", q_at(fp_a, 1) - q_at(dn_a, 0) - 1, LAT_A);
        chk("cont_plot_gap_2", q_at(fp_a, 2) - q_at(dn_a, 1) - 1, LAT_A);
        chk("cont_queue_empty", qa.size(), 0);
        chk("cont_idle_after", 32'(busy_a), 0);

        // Reset in the middle of a frame at (150,1), then repaint.
        clear_logs();
        start_a = 1'b1; push_frame(1'b0, H_A, V_A);
        step(); start_a = 1'b0;
        t = 0;
        while (!(plot_a && x_a == 9'd150 && y_a == 8'd1) && t < N_A + 10) begin
            step();
            t++;
        end
        chk("abort_point_found", 32'(plot_a && x_a == 9'd150 && y_a == 8'd1), 1);
        rst_a = 1'b1;
        step();
        chk("abort_plot_busy", 32'({plot_a, busy_a, done_a}), 0);
        qa.delete();
        rst_a = 1'b0;
        repeat (N_A + 20) step();
        chk("abort_no_done", dn_a.size(), 0);
        clear_logs();
        c0 = cyc; start_a = 1'b1; push_frame(1'b0, H_A, V_A);
        step(); start_a = 1'b0;
        wait_done(1'b0, 1, N_A + 50);
        chk("repaint_first_plot", q_at(fp_a, 0) - c0, 1 + LAT_A);
        chk("repaint_period", q_at(dn_a, 0) - c0, N_A + LAT_A);
        chk("repaint_queue_empty", qa.size(), 0);

        // Small raster, three-cycle source.
        clear_logs();
        c0 = cyc; start_b = 1'b1; push_frame(1'b1, H_B, V_B);
        step(); start_b = 1'b0;
        wait_done(1'b1, 1, 40);
        repeat (3) step();
        chk("b_first_plot_lat", q_at(fp_b, 0) - c0, 1 + LAT_B);
        chk("b_frame_period", q_at(dn_b, 0) - c0, N_B + LAT_B);
        chk("b_queue_empty", qb.size(), 0);
        chk("b_idle_after", 32'(busy_b), 0);

        clear_logs();
        c0 = cyc; cont_b = 1'b1;
        push_frame(1'b1, H_B, V_B); push_frame(1'b1, H_B, V_B);
        wait_done(1'b1, 1, 40);
        repeat (2) step();
        cont_b = 1'b0;
        wait_done(1'b1, 2, 40);
        repeat (20) step();
        chk("b_cont_done_count", dn_b.size(), 2);
        chk("b_cont_spacing", q_at(dn_b, 1) - q_at(dn_b, 0), N_B + LAT_B);
        chk("b_cont_plot_gap", q_at(fp_b, 1) - q_at(dn_b, 0) - 1, LAT_B);
        chk("b_cont_queue_empty", qb.size(), 0);
        chk("b_cont_idle_after", 32'(busy_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
